// File: rtl/alu_mdu.sv
// ALU with iterative multiply/divide unit; one request in flight, registered
// result behind a valid/ready handshake.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic [XLEN-1:0] result,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} st_t;

  st_t             state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      fn_q;
  logic [XLEN-1:0] a_q, mc_q, res_q;
  logic [2*XLEN-1:0] prod_q;
  logic            nq_q, nr_q, bz_q;

  logic            accept, m_op, sa, sb, is_div;
  logic [2:0]      fn;
  logic [XLEN-1:0] ma, mb, alu;

  assign fn     = op[2:0];
  assign m_op   = op[4] & ~op[3];
  assign is_div = fn[2];
  assign sa     = (fn == 3'd1) | (fn == 3'd2) | (fn == 3'd4) | (fn == 3'd6);
  assign sb     = (fn == 3'd1) | (fn == 3'd4) | (fn == 3'd6);
  assign ma     = (sa & srcA[XLEN-1]) ? -srcA : srcA;
  assign mb     = (sb & srcB[XLEN-1]) ? -srcB : srcB;
  assign accept = in_valid & in_ready;

  always_comb begin
    alu = '0;
    if (!op[4]) begin
      case (op[3:0])
        4'd0:  alu = srcA + srcB;
        4'd1:  alu = srcA - srcB;
        4'd2:  alu = srcA & srcB;
        4'd3:  alu = srcA | srcB;
        4'd4:  alu = srcA ^ srcB;
        4'd5:  alu = srcA << srcB[SHW-1:0];
        4'd6:  alu = srcA >> srcB[SHW-1:0];
        4'd7:  alu = $signed(srcA) >>> srcB[SHW-1:0];
        4'd8:  alu = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
        4'd9:  alu = {{(XLEN-1){1'b0}}, srcA < srcB};
        4'd10: alu = srcA;
        4'd11: alu = srcB;
        default: alu = '0;
      endcase
    end
  end

  // Iteration step on magnitudes: shift-add or restoring subtract
  logic [XLEN:0]     sum, rt, diff;
  logic              ge;
  logic [2*XLEN-1:0] nx, pn;
  logic [XLEN-1:0]   qv, rv, fin;

  always_comb begin
    sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mc_q} : '0);
    rt   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    diff = rt - {1'b0, mc_q};
    ge   = ~diff[XLEN];
    if (fn_q[2])
      nx = {ge ? diff[XLEN-1:0] : rt[XLEN-1:0], prod_q[XLEN-2:0], ge};
    else
      nx = {sum, prod_q[XLEN-1:1]};
    pn = nq_q ? -nx : nx;
    qv = nq_q ? -nx[XLEN-1:0] : nx[XLEN-1:0];
    rv = nr_q ? -nx[2*XLEN-1:XLEN] : nx[2*XLEN-1:XLEN];
    if (!fn_q[2])
      fin = (fn_q == 3'd0) ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN];
    else if (fn_q[1])
      fin = bz_q ? a_q : rv;
    else
      fin = bz_q ? '1 : qv;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = m_op ? CALC : DONE;
      CALC: if (cnt_q == CW'(1)) state_d = DONE;
      DONE: begin
        if (accept)         state_d = m_op ? CALC : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    out_valid = (state_q == DONE);
    result    = out_valid ? res_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      fn_q   <= '0;
      a_q    <= '0;
      mc_q   <= '0;
      prod_q <= '0;
      res_q  <= '0;
      nq_q   <= 1'b0;
      nr_q   <= 1'b0;
      bz_q   <= 1'b0;
    end else if (accept) begin
      if (m_op) begin
        cnt_q  <= CW'(XLEN);
        fn_q   <= fn;
        a_q    <= srcA;
        bz_q   <= (srcB == '0);
        mc_q   <= is_div ? mb : ma;
        prod_q <= {{XLEN{1'b0}}, is_div ? ma : mb};
        nq_q   <= (sa & srcA[XLEN-1]) ^ (sb & srcB[XLEN-1]);
        nr_q   <= sa & srcA[XLEN-1];
      end else begin
        res_q <= alu;
        cnt_q <= '0;
      end
    end else if (state_q == CALC) begin
      prod_q <= nx;
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) res_q <= fin;
    end
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (power of 2, >= 8).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount bits taken from srcB.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port op  input  5  operation select (encoding REQ-011).
REQ-008 SHALL have ports srcA, srcB  input  XLEN  operands.
REQ-009 SHALL have ports result  output  XLEN, out_valid  output  1, out_ready  input  1  registered result handshake.

Function
REQ-010 Request accepted on an edge where in_valid && in_ready; op/srcA/srcB captured then; later input changes SHALL NOT affect that result.
REQ-011 op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 pass A, 11 pass B, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; any other code = base op with result 0.
REQ-012 Base ops (op<16): shifts use srcB[SHW-1:0]; SRA arithmetic; SLT signed, SLTU unsigned compare, result 0/1 zero-extended; add/sub wrap modulo 2^XLEN.
REQ-013 MUL = low XLEN bits of product; MULH signed x signed, MULHSU signed srcA x unsigned srcB, MULHU unsigned x unsigned, all high XLEN bits of 2*XLEN product.
REQ-014 DIV/REM signed, quotient truncated toward zero, remainder sign = dividend sign; DIVU/REMU unsigned.
REQ-015 Divide by zero: quotient = all ones, remainder = srcA; no exception output.
REQ-016 Signed overflow (srcA = -2^(XLEN-1), srcB = -1): DIV = srcA, REM = 0.
REQ-017 FSM states IDLE, CALC, DONE. IDLE+accept, base op -> DONE with result loaded. IDLE+accept, MUL*/DIV*/REM* -> CALC, iteration counter = XLEN.
REQ-018 CALC: one shift-add (mul) or restoring-subtract (div) step per cycle, counter decrements; on the XLEN-th CALC edge result loaded, -> DONE. Latency fixed regardless of operand values (incl. REQ-015/016 cases).
REQ-019 Latency: out_valid first high 1 edge after accept for base ops, XLEN+1 edges after accept for M ops.
REQ-020 out_valid = (state==DONE). in_ready = (state==IDLE) || (state==DONE && out_ready); in CALC in_ready = 0.
REQ-021 DONE && !out_ready: result and out_valid SHALL hold stable.
REQ-022 DONE && out_ready && !in_valid -> IDLE; DONE && out_ready && in_valid -> same edge accepts new request (back-to-back, no bubble), next state per REQ-017.
REQ-023 result SHALL be driven 0 whenever out_valid = 0.
REQ-024 One transaction in flight maximum; no reordering.

Reset
REQ-025 rst high on an edge: state -> IDLE, counter 0, internal operand/accumulator registers 0; next cycle out_valid = 0, result = 0, in_ready = 1.
REQ-026 rst has priority over accept and over CALC/DONE progress; an in-flight M op is discarded and never produces out_valid.
REQ-027 in_valid during rst cycle SHALL NOT be accepted.

Verification (XLEN=32)
REQ-028 ADD srcA=5 srcB=7, out_ready=1 -> out_valid 1 edge after accept, result=12; SUB 0-1 -> 0xFFFFFFFF; SRA 0x80000000 by srcB=0x24 -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1, SLTU -> 0.
REQ-029 MUL/MULHU/MULH on 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001 / 0xFFFFFFFE / 0x00000000, each out_valid exactly 33 edges after accept, in_ready=0 throughout CALC; MULHSU same operands -> 0xFFFFFFFF.
REQ-030 DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7, DIVU -7/2 (0xFFFFFFF9/2) -> 0x7FFFFFFC, DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with REM -> 0, all 33-edge latency.
REQ-031 Backpressure: ADD result ready, out_ready=0 for 5 cycles -> result/out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 (XOR 0xF0,0xFF) -> accepted same edge, next cycle result=0x0F.
REQ-032 rst pulsed at 10th CALC cycle of a DIV -> next cycle out_valid=0, result=0, in_ready=1; following ADD 1+1 -> 2 after 1 edge, no stale DIV result ever appears.
REQ-033 Illegal op 31 -> result 0, out_valid 1 edge after accept; input change after accept (srcA altered during CALC) -> result unaffected.
